cpu_pause_gate: RTL and testbench



---
 rtl/cpu_pause_gate.sv | 137 +++++++++++++
 tb/tb_cpu_pause_gate.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_pause_gate.sv
// Generates the 6809-style Q/E CPU clock enables and parks the CPU on a
// bus-cycle boundary on request, acknowledging once the bus has settled.
module cpu_pause_gate #(
  parameter int DIV        = 8,
  parameter int SETTLE     = 16,
  parameter int RESUME_DLY = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        pause_req,
  output logic        cpu_cen_q,
  output logic        cpu_cen_e,
  output logic        cpu_halted,
  output logic        pause_ack,
  output logic [15:0] lost_cycles
);

  localparam int PW      = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int CNT_MAX = (SETTLE > RESUME_DLY) ? SETTLE : RESUME_DLY;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [PW-1:0] PH_Q        = PW'(DIV / 2 - 1);
  localparam logic [PW-1:0] PH_E        = PW'(DIV - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] RESUME_LAST = CW'(RESUME_DLY - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALT    = 2'd1,
    SETTLED = 2'd2,
    RESUME  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   lost_q, lost_d;
  logic          cen_q_pulse_q, cen_q_pulse_d;
  logic          cen_e_pulse_q, cen_e_pulse_d;
  logic          halted_q, halted_d;
  logic          ack_q, ack_d;
  logic          cycle_end;

  assign cycle_end = (phase_q == PH_E);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // A halt is only taken on the E edge so the CPU never sees a truncated cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (cycle_end && pause_req) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (!pause_req) begin
          state_d = RESUME;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = SETTLED;
        end
      end
      SETTLED: begin
        if (!pause_req) begin
          state_d = RESUME;
        end
      end
      RESUME: begin
        if (pause_req) begin
          state_d = HALT;
        end else if (cnt_q == RESUME_LAST) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    phase_d = '0;
    if (state_q == RUN && !cycle_end) begin
      phase_d = phase_q + PW'(1);
    end

    // The timer restarts on every state change so each wait is measured fresh.
    cnt_d = '0;
    if (state_d == state_q && (state_q == HALT || state_q == RESUME)) begin
      cnt_d = cnt_q + CW'(1);
    end

    lost_d = lost_q;
    if (state_q != RUN && lost_q != 16'hFFFF) begin
      lost_d = lost_q + 16'd1;
    end
  end

  always_comb begin
    cen_q_pulse_d = (state_d == RUN) && (phase_d == PH_Q);
    cen_e_pulse_d = (state_d == RUN) && (phase_d == PH_E);
    halted_d      = (state_d != RUN);
    ack_d         = (state_d == SETTLED);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      phase_q       <= '0;
      cnt_q         <= '0;
      lost_q        <= '0;
      cen_q_pulse_q <= 1'b0;
      cen_e_pulse_q <= 1'b0;
      halted_q      <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      lost_q        <= lost_d;
      cen_q_pulse_q <= cen_q_pulse_d;
      cen_e_pulse_q <= cen_e_pulse_d;
      halted_q      <= halted_d;
      ack_q         <= ack_d;
    end
  end

  assign cpu_cen_q   = cen_q_pulse_q;
  assign cpu_cen_e   = cen_e_pulse_q;
  assign cpu_halted  = halted_q;
  assign pause_ack   = ack_q;
  assign lost_cycles = lost_q;

endmodule

// File: tb/tb_cpu_pause_gate.sv
// Directed bench for cpu_pause_gate: a cycle-level behavioural model is
// compared every cycle, and hand-computed latencies pin the model itself.
module tb_cpu_pause_gate;

  localparam int DIV        = 8;
  localparam int SETTLE     = 16;
  localparam int RESUME_DLY = 4;

  logic        clk_sys   = 1'b0;
  logic        reset_n   = 1'b0;
  logic        pause_req = 1'b0;
  logic        cpu_cen_q;
  logic        cpu_cen_e;
  logic        cpu_halted;
  logic        pause_ack;
  logic [15:0] lost_cycles;

  int assert_count = 0;
  int fail_count   = 0;

  cpu_pause_gate #(
    .DIV(DIV),
    .SETTLE(SETTLE),
    .RESUME_DLY(RESUME_DLY)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .pause_req(pause_req),
    .cpu_cen_q(cpu_cen_q),
    .cpu_cen_e(cpu_cen_e),
    .cpu_halted(cpu_halted),
    .pause_ack(pause_ack),
    .lost_cycles(lost_cycles)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: actual %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which mode the CPU is in, where in the CPU cycle it is,
  // and how long it has been waiting in the current mode.
  typedef enum int {M_RUN, M_HALT, M_SETTLED, M_RESUME} mode_t;
  mode_t m_mode  = M_RUN;
  int    m_phase = 0;
  int    m_age   = 0;
  int    m_lost  = 0;
  bit    m_valid = 1'b0;
  bit    m_rst   = 1'b0;

  task automatic modelStep();
    if (!reset_n) begin
      m_mode  = M_RUN;
      m_phase = 0;
      m_age   = 0;
      m_lost  = 0;
      m_valid = 1'b1;
      m_rst   = 1'b1;
    end else if (m_valid) begin
      m_rst = 1'b0;
      if (m_mode != M_RUN) m_lost = (m_lost < 65535) ? m_lost + 1 : 65535;
      case (m_mode)
        M_RUN: begin
          if (m_phase == DIV - 1 && pause_req) begin
            m_mode  = M_HALT;
            m_age   = 0;
            m_phase = 0;
          end else begin
            m_phase = (m_phase + 1) % DIV;
          end
        end
        M_HALT: begin
          m_age++;
          if (!pause_req) begin
            m_mode = M_RESUME;
            m_age  = 0;
          end else if (m_age == SETTLE) begin
            m_mode = M_SETTLED;
          end
        end
        M_SETTLED: begin
          if (!pause_req) begin
            m_mode = M_RESUME;
            m_age  = 0;
          end
        end
        M_RESUME: begin
          m_age++;
          if (pause_req) begin
            m_mode = M_HALT;
            m_age  = 0;
          end else if (m_age == RESUME_DLY) begin
            m_mode  = M_RUN;
            m_phase = 0;
          end
        end
        default: m_mode = M_RUN;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk_sys);
    modelStep();
  end

  initial forever begin
    @(negedge clk_sys);
    if (m_valid) begin
      bit run;
      run = !m_rst && (m_mode == M_RUN);
      checkOutput("cen_q", cpu_cen_q, run && (m_phase == DIV / 2 - 1));
      checkOutput("cen_e", cpu_cen_e, run && (m_phase == DIV - 1));
      checkOutput("halted", cpu_halted, !m_rst && (m_mode != M_RUN));
      checkOutput("ack", pause_ack, !m_rst && (m_mode == M_SETTLED));
      checkOutput("lost_cycles", lost_cycles, m_lost);
    end
  end

  task automatic applyStimulus(input logic rst_n, input logic req);
    @(negedge clk_sys);
    reset_n   = rst_n;
    pause_req = req;
  endtask

  task automatic waitPhase(input int p);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk_sys);
      if (m_mode == M_RUN && m_phase == p) found = 1'b1;
    end
    if (!found) checkOutput("waitPhase timeout", 0, 1);
  endtask

  // Observe n negedges, reporting first index (1-based) of each event, 0 if none.
  task automatic observe(input int n, output int first_q, output int first_e,
                         output int first_halt, output int first_run, output int first_ack,
                         output int n_q, output int n_e, output int n_halt);
    first_q = 0; first_e = 0; first_halt = 0; first_run = 0; first_ack = 0;
    n_q = 0; n_e = 0; n_halt = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk_sys);
      if (cpu_cen_q) begin n_q++; if (first_q == 0) first_q = i; end
      if (cpu_cen_e) begin n_e++; if (first_e == 0) first_e = i; end
      if (cpu_halted) begin n_halt++; if (first_halt == 0) first_halt = i; end
      if (!cpu_halted && first_run == 0) first_run = i;
      if (pause_ack && first_ack == 0) first_ack = i;
    end
  endtask

  initial begin
    int fq, fe, fh, fr, fa, nq, ne, nh;
    bit got;

    // Reset values
    repeat (3) @(negedge clk_sys);
    checkOutput("reset cen_q", cpu_cen_q, 0);
    checkOutput("reset cen_e", cpu_cen_e, 0);
    checkOutput("reset halted", cpu_halted, 0);
    checkOutput("reset ack", pause_ack, 0);
    checkOutput("reset lost", lost_cycles, 0);

    // Free run for 64 cycles
    reset_n = 1'b1;
    observe(64, fq, fe, fh, fr, fa, nq, ne, nh);
    checkOutput("freerun q count", nq, 8);
    checkOutput("freerun e count", ne, 8);
    checkOutput("freerun first q", fq, 3);
    checkOutput("freerun first e", fe, 7);
    checkOutput("freerun halted", nh, 0);

    // Short pulse across phases 1..3 never reaches the cycle boundary
    waitPhase(1);
    pause_req = 1'b1;
    repeat (3) @(negedge clk_sys);
    pause_req = 1'b0;
    observe(16, fq, fe, fh, fr, fa, nq, ne, nh);
    checkOutput("pulse halted", nh, 0);
    checkOutput("pulse q count", nq, 2);
    checkOutput("pulse e count", ne, 2);
    checkOutput("pulse lost", lost_cycles, 0);

    // Request at phase 2: E still fires at phase 7, then halt and settle
    waitPhase(2);
    pause_req = 1'b1;
    observe(5, fq, fe, fh, fr, fa, nq, ne, nh);
    checkOutput("halt last e", fe, 5);
    checkOutput("halt last q", fq, 1);
    observe(20, fq, fe, fh, fr, fa, nq, ne, nh);
    checkOutput("halt entry", fh, 1);
    checkOutput("halt ack latency", fa - fh, SETTLE);
    checkOutput("halt enables", nq + ne, 0);

    // Release from SETTLED
    applyStimulus(1'b1, 1'b0);
    @(negedge clk_sys);
    checkOutput("release ack drop", pause_ack, 0);
    observe(11, fq, fe, fh, fr, fa, nq, ne, nh);
    checkOutput("release run entry", fr + 1, 5);
    checkOutput("release first q", fq + 1, 8);
    checkOutput("release first e", fe + 1, 12);

    // Re-request on the second RESUME cycle restarts the settle interval
    pause_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk_sys);
      if (pause_ack) got = 1'b1;
    end
    checkOutput("rerequest first ack", got, 1);
    pause_req = 1'b0;
    repeat (2) @(negedge clk_sys);
    pause_req = 1'b1;
    observe(30, fq, fe, fh, fr, fa, nq, ne, nh);
    checkOutput("rerequest ack", fa + 2, 19);
    checkOutput("rerequest enables", nq + ne, 0);

    // Long pause saturates lost_cycles
    repeat (70000) @(negedge clk_sys);
    checkOutput("saturated lost", lost_cycles, 16'hFFFF);
    checkOutput("saturated ack", pause_ack, 1);

    // Reset in the middle of a pause
    applyStimulus(1'b0, 1'b1);
    @(negedge clk_sys);
    checkOutput("midreset halted", cpu_halted, 0);
    checkOutput("midreset ack", pause_ack, 0);
    checkOutput("midreset lost", lost_cycles, 0);
    checkOutput("midreset cen_e", cpu_cen_e, 0);
    pause_req = 1'b0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    observe(8, fq, fe, fh, fr, fa, nq, ne, nh);
    checkOutput("postreset first q", fq, 3);
    checkOutput("postreset first e", fe, 7);
    checkOutput("postreset halted", nh, 0);

    // Request rising on the reset release edge waits for the cycle boundary
    applyStimulus(1'b0, 1'b0);
    @(negedge clk_sys);
    reset_n   = 1'b1;
    pause_req = 1'b1;
    observe(10, fq, fe, fh, fr, fa, nq, ne, nh);
    checkOutput("simul first e", fe, 7);
    checkOutput("simul halt", fh, 8);
    pause_req = 1'b0;
    repeat (12) @(negedge clk_sys);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
